playback_scheduler: RTL
=======================

# playback_scheduler

Sequences sheet-music playback for the piano: owns the frame counter and tempo timebase, fetches one 63-bit note frame per tempo period from an external synchronous sheet ROM, and merges the held sheet frame with live keyboard keys into the single note vector that drives the tone generators. Adds play/pause/stop control, optional looping, a beat indicator and an end-of-song pulse. Sits between the user-input debouncers, the sheet ROM and the tone-synthesis bank.

## Interface
- FRAME_CNT, 1296: number of sheet frames in the song.
- ADDR_W, 11: ROM address width; must satisfy 2^ADDR_W >= FRAME_CNT.
- TICK_PERIOD, 8333332: clk cycles per frame; minimum 4.
- BEATS, 6: width of beat_display; one beat spans 2 frames.
- LOOP, 1: 1 = restart at frame 0 after the last frame; 0 = stop.

- clk_100mhz  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  reset rst_n, asynchronous, active-high.
- play_pause  in  1  single-cycle pulse; start / pause / resume.
- stop  in  1  single-cycle pulse; abort playback, return to frame 0.
- live_keys  in  63  currently pressed keyboard notes.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM frame address.
- rom_data  in  63  ROM frame; valid the cycle after rom_en=1.
- note_out  out  63  registered merged note vector.
- beat_display  out  BEATS  one-hot beat indicator, MSB = first beat.
- playing  out  1  high in FETCH, LOAD, PLAY.
- song_done  out  1  one-cycle pulse when the last frame's period expires.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, PAUSE. Reset: IDLE, frame=0, tick=0, sheet_hold=0, pause_pending=0, all outputs 0.
- IDLE: frame=0, tick=0, sheet_hold=0. play_pause -> FETCH.
- FETCH: rom_en=1, rom_addr=frame for exactly one cycle -> LOAD.
- LOAD: sheet_hold <= rom_data. If frame is even, beat_display <= one-hot bit (BEATS-1 - (frame/2)%BEATS); odd frames hold beat_display. -> PAUSE if pause_pending (then clear it), else PLAY.
- Tick counter increments every cycle in FETCH, LOAD and PLAY; frozen in PAUSE; 0 in IDLE.
- PLAY, tick==TICK_PERIOD-1: tick<=0. If frame<FRAME_CNT-1: frame+1, -> FETCH. If frame==FRAME_CNT-1: song_done=1; LOOP=1 -> frame=0, FETCH; LOOP=0 -> IDLE (sheet_hold, beat_display cleared).
- PLAY, play_pause -> PAUSE. PAUSE, play_pause -> PLAY, tick resumes from frozen value.
- play_pause in FETCH or LOAD sets pause_pending; a second pulse before LOAD completes clears it.
- stop in any state -> IDLE next cycle; clears frame, tick, sheet_hold, beat_display, pause_pending.
- Priority in one cycle: stop > play_pause > tick expiry. play_pause coinciding with expiry in PLAY -> PAUSE, frame not advanced, tick frozen at TICK_PERIOD-1 (expiry occurs on resume cycle).
- note_out <= live_keys | (state in {FETCH, LOAD, PLAY} ? sheet_hold : 0). In PAUSE and IDLE only live keys pass.
- frame is ADDR_W bits, compared against FRAME_CNT-1, never wraps past it.

## Timing
- Frame period in steady playback: exactly TICK_PERIOD cycles (FETCH and LOAD count toward it).
- play_pause at cycle 0 in IDLE: FETCH at 1 (rom_en=1, rom_addr=0), LOAD at 2, sheet_hold valid at 3, note_out reflects it at 4.
- live_keys -> note_out: 1 cycle latency in all states.
- song_done asserted for the single expiry cycle; playing drops the cycle after when LOOP=0.
- rst_n asserted mid-operation: all state and outputs to reset values immediately, independent of clk.

## Test plan
- TICK_PERIOD=8, FRAME_CNT=4, LOOP=0, ROM[i]=1<<i: play_pause -> note_out = 1,2,4,8 each for 8 cycles, song_done pulse once, then IDLE, note_out=0, playing=0.
- Same with LOOP=1: after frame 3, rom_addr returns to 0, note_out=1 again, song_done each 32 cycles, playing stays 1.
- Pause at tick 3 of frame 1, hold 20 cycles, resume: note_out sheet part 0 during pause, frame 1 lasts 8 playing cycles total, beat_display unchanged.
- live_keys=0x5 while frame ROM=0x2 playing -> note_out=0x7; in PAUSE -> 0x5.
- stop and play_pause in same cycle during PLAY -> IDLE, frame=0, note_out=live_keys only; play_pause during FETCH -> lands in PAUSE after LOAD.
- FRAME_CNT=16, BEATS=6: beat_display sequence 100000,100000,010000,010000,... repeating every 12 frames; assert rst_n mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/playback_scheduler.sv
// Sheet-music playback sequencer: owns the frame counter and tempo timebase,
// fetches one ROM frame per tempo period and merges it with live keyboard keys.
module playback_scheduler #(
  parameter int FRAME_CNT   = 1296,
  parameter int ADDR_W      = 11,
  parameter int TICK_PERIOD = 8333332,
  parameter int BEATS       = 6,
  parameter int LOOP        = 1
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              play_pause,
  input  logic              stop,
  input  logic [62:0]       live_keys,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [62:0]       rom_data,
  output logic [62:0]       note_out,
  output logic [BEATS-1:0]  beat_display,
  output logic              playing,
  output logic              song_done
);

  localparam int                TICK_W     = $clog2(TICK_PERIOD);
  localparam logic [ADDR_W-1:0] LAST_FRAME = ADDR_W'(FRAME_CNT - 1);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(TICK_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] frame_r;
  logic [TICK_W-1:0] tick_r;
  logic [62:0]       sheet_hold_r;
  logic              pause_pending_r;

  logic              expiry_s;
  logic              last_frame_s;
  logic              sheet_live_s;
  logic              pend_next_s;
  int                beat_sel_s;
  logic [BEATS-1:0]  beat_onehot_s;
  logic [ADDR_W-1:0] frame_inc_s;
  logic [TICK_W-1:0] tick_inc_s;

  // Decode of the current state: period expiry, sheet gating, beat position.
  always_comb begin
    expiry_s      = (state_r == S_PLAY) && (tick_r == LAST_TICK);
    last_frame_s  = (frame_r == LAST_FRAME);
    sheet_live_s  = (state_r == S_FETCH) || (state_r == S_LOAD) || (state_r == S_PLAY);
    pend_next_s   = pause_pending_r ^ play_pause;
    beat_sel_s    = BEATS - 1 - (int'(frame_r >> 1) % BEATS);
    beat_onehot_s = BEATS'(1'b1) << beat_sel_s;
    frame_inc_s   = frame_r + ADDR_W'(1'b1);
    tick_inc_s    = tick_r + TICK_W'(1'b1);
  end

  // Pulses during the expiry cycle itself; stop and play_pause pre-empt it.
  assign song_done = expiry_s && last_frame_s && !stop && !play_pause;

  // Playback FSM with tick/frame counters and registered outputs.
  always_ff @(posedge clk_100mhz or posedge rst_n) begin
    if (rst_n) begin
      state_r         <= S_IDLE;
      frame_r         <= '0;
      tick_r          <= '0;
      sheet_hold_r    <= '0;
      pause_pending_r <= 1'b0;
      rom_en          <= 1'b0;
      rom_addr        <= '0;
      note_out        <= '0;
      beat_display    <= '0;
      playing         <= 1'b0;
    end else begin
      rom_en   <= 1'b0;
      note_out <= live_keys | (sheet_live_s ? sheet_hold_r : 63'd0);
      if (stop) begin
        state_r         <= S_IDLE;
        frame_r         <= '0;
        tick_r          <= '0;
        sheet_hold_r    <= '0;
        pause_pending_r <= 1'b0;
        beat_display    <= '0;
        playing         <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (play_pause) begin
              state_r  <= S_FETCH;
              rom_en   <= 1'b1;
              rom_addr <= frame_r;
              playing  <= 1'b1;
            end
          end
          S_FETCH: begin
            tick_r          <= tick_inc_s;
            state_r         <= S_LOAD;
            pause_pending_r <= pend_next_s;
          end
          S_LOAD: begin
            tick_r          <= tick_inc_s;
            sheet_hold_r    <= rom_data;
            pause_pending_r <= 1'b0;
            if (!frame_r[0]) begin
              beat_display <= beat_onehot_s;
            end
            if (pend_next_s) begin
              state_r <= S_PAUSE;
              playing <= 1'b0;
            end else begin
              state_r <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (play_pause) begin
              // Pausing on the expiry tick keeps it pending for the resume cycle.
              state_r <= S_PAUSE;
              playing <= 1'b0;
              if (!expiry_s) begin
                tick_r <= tick_inc_s;
              end
            end else if (expiry_s) begin
              tick_r <= '0;
              if (!last_frame_s) begin
                frame_r  <= frame_inc_s;
                state_r  <= S_FETCH;
                rom_en   <= 1'b1;
                rom_addr <= frame_inc_s;
              end else if (LOOP != 0) begin
                frame_r  <= '0;
                state_r  <= S_FETCH;
                rom_en   <= 1'b1;
                rom_addr <= '0;
              end else begin
                frame_r      <= '0;
                state_r      <= S_IDLE;
                sheet_hold_r <= '0;
                beat_display <= '0;
                playing      <= 1'b0;
              end
            end else begin
              tick_r <= tick_inc_s;
            end
          end
          S_PAUSE: begin
            if (play_pause) begin
              state_r <= S_PLAY;
              playing <= 1'b1;
            end
          end
          default: begin
            state_r         <= S_IDLE;
            frame_r         <= '0;
            tick_r          <= '0;
            sheet_hold_r    <= '0;
            pause_pending_r <= 1'b0;
            beat_display    <= '0;
            playing         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
